// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: arbitrates divisor-change requests from two requesters and
// sequences the downstream clock divider through reset, reload and settle.
// A legal request holds the divider in reset for two cycles, loads the new
// divisor as reset is released, waits SETTLE_CYC cycles, then acks.
// Divisors below 2 are rejected immediately with err alongside ack.
module clk_div_ctrl #(
  parameter int unsigned DEFAULT_MODE = 2,
  parameter int unsigned SETTLE_CYC   = 4
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [30:0] mode0,
  input  logic [30:0] mode1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [30:0] clk_mode,
  output logic        div_rst_n,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_reg, state_next;

  // Requester that owns the current transaction and whether it was rejected
  logic        grant_reg, grant_next;
  logic        rej_reg, rej_next;

  // Round-robin pointer: 0 favours req0 on a tie, 1 favours req1
  logic        prio_reg, prio_next;

  // Divisor latched at grant time; req/mode are ignored after leaving IDLE
  logic [30:0] mode_reg, mode_next;

  // HOLD is two cycles long: hold_cnt_reg marks the second one
  logic        hold_cnt_reg, hold_cnt_next;
  logic [7:0]  settle_cnt_reg, settle_cnt_next;

  logic [30:0] clk_mode_reg, clk_mode_next;
  logic        div_rst_n_reg, div_rst_n_next;

  // Arbitration results for the current cycle
  logic [1:0]  req_vec;
  logic        any_req;
  logic        grant_sel;
  logic [30:0] mode_sel;
  logic        mode_illegal;

  logic [1:0]  ack_vec;
  logic [1:0]  err_vec;

  assign req_vec = {req1, req0};
  assign any_req = |req_vec;

  // Pick a requester: on a tie use the pointer, otherwise whoever is asking
  always_comb begin
    grant_sel = 1'b0;
    if (req_vec == 2'b11) begin
      grant_sel = prio_reg;
    end else begin
      grant_sel = req_vec[1];
    end
  end

  assign mode_sel     = grant_sel ? mode1 : mode0;
  // Unsigned comparison across all 31 bits, so large divisors stay legal
  assign mode_illegal = (mode_sel < 31'd2);

  // Next-state and datapath decisions for the sequencing FSM
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    rej_next        = rej_reg;
    prio_next       = prio_reg;
    mode_next       = mode_reg;
    hold_cnt_next   = hold_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    clk_mode_next   = clk_mode_reg;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next    = grant_sel;
          prio_next     = ~grant_sel;
          mode_next     = mode_sel;
          rej_next      = mode_illegal;
          hold_cnt_next = 1'b0;
          state_next    = mode_illegal ? DONE : HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_reg) begin
          // New divisor appears exactly as the divider leaves reset
          clk_mode_next   = mode_reg;
          settle_cnt_next = 8'(SETTLE_CYC - 1);
          state_next      = SETTLE;
        end else begin
          hold_cnt_next = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt_reg == 8'd0) begin
          state_next = DONE;
        end else begin
          settle_cnt_next = settle_cnt_reg - 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Divider reset is low only while the FSM sits in HOLD
    div_rst_n_next = (state_next != HOLD);
  end

  // State register
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Transaction bookkeeping and downstream divider outputs
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      grant_reg      <= 1'b0;
      rej_reg        <= 1'b0;
      prio_reg       <= 1'b0;
      mode_reg       <= 31'd0;
      hold_cnt_reg   <= 1'b0;
      settle_cnt_reg <= 8'd0;
      clk_mode_reg   <= 31'(DEFAULT_MODE);
      div_rst_n_reg  <= 1'b0;
    end else begin
      grant_reg      <= grant_next;
      rej_reg        <= rej_next;
      prio_reg       <= prio_next;
      mode_reg       <= mode_next;
      hold_cnt_reg   <= hold_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      clk_mode_reg   <= clk_mode_next;
      div_rst_n_reg  <= div_rst_n_next;
    end
  end

  // Completion pulses go only to the requester that owns the transaction
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign ack_vec[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
    assign err_vec[gi] = ack_vec[gi] && rej_reg;
  end

  assign ack0      = ack_vec[0];
  assign ack1      = ack_vec[1];
  assign err0      = err_vec[0];
  assign err1      = err_vec[1];
  assign clk_mode  = clk_mode_reg;
  assign div_rst_n = div_rst_n_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed requests, expected acks queued in a
// scoreboard and checked by an independent negedge monitor.
module tb_clk_div_ctrl;

  logic        clk_100MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [30:0] mode0 = 31'd0;
  logic [30:0] mode1 = 31'd0;
  logic        ack0, ack1, err0, err1;
  logic [30:0] clk_mode;
  logic        div_rst_n;
  logic        busy;

  clk_div_ctrl #(
    .DEFAULT_MODE(2),
    .SETTLE_CYC(4)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n(rst_n),
    .req0(req0),
    .req1(req1),
    .mode0(mode0),
    .mode1(mode1),
    .ack0(ack0),
    .ack1(ack1),
    .err0(err0),
    .err1(err1),
    .clk_mode(clk_mode),
    .div_rst_n(div_rst_n),
    .busy(busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  typedef struct {
    int who;
    int err;
    int mode;
    int cyc;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  bit ack0_q = 1'b0;
  bit ack1_q = 1'b0;
  bit keep0 = 1'b0;
  bit keep1 = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: records acks for the requester model and scores each completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100MHz);
      ack0_q = ack0;
      ack1_q = ack1;
      if (err0 || err1) chk("err_without_ack", int'((err0 & ~ack0) | (err1 & ~ack1)), 0);
      if (ack0 || ack1) begin
        chk("ack_overlap", int'(ack0 & ack1), 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_ack_cycle", cyc, -1);
        end else begin
          e = sb_q.pop_front();
          chk("ack_who", ack1 ? 1 : 0, e.who);
          chk("ack_err", ack1 ? int'(err1) : int'(err0), e.err);
          chk("ack_clk_mode", int'(clk_mode), e.mode);
          chk("ack_cycle", cyc, e.cyc);
          $display("txn: requester %0d err %0d clk_mode %0d at cycle %0d (expected cycle %0d)",
                   ack1 ? 1 : 0, ack1 ? int'(err1) : int'(err0), clk_mode, cyc, e.cyc);
        end
      end
    end
  end

  // Move to just after the next rising edge; requesters drop req on their ack edge
  task automatic adv();
    @(posedge clk_100MHz);
    #1;
    if (ack0_q && !keep0) req0 = 1'b0;
    if (ack1_q && !keep1) req1 = 1'b0;
  endtask

  task automatic advn(input int n);
    for (int i = 0; i < n; i++) adv();
  endtask

  task automatic at_neg();
    @(negedge clk_100MHz);
  endtask

  initial begin
    int t;

    // Reset state
    advn(3);
    at_neg();
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack0 | ack1), 0);
    chk("rst_err", int'(err0 | err1), 0);
    chk("rst_clk_mode", int'(clk_mode), 2);
    chk("rst_div_rst_n", int'(div_rst_n), 0);
    adv();
    rst_n = 1'b1;
    adv();
    at_neg();
    chk("rel_div_rst_n", int'(div_rst_n), 1);
    chk("rel_busy", int'(busy), 0);
    adv();

    // Single legal request, divisor 5
    t = cyc;
    req0 = 1'b1;
    mode0 = 31'd5;
    sb_q.push_back(exp_t'{0, 0, 5, t + 7});
    for (int k = 0; k <= 8; k++) begin
      at_neg();
      if (k >= 1) begin
        chk($sformatf("legal_div_rst_n_k%0d", k), int'(div_rst_n), (k == 1 || k == 2) ? 0 : 1);
        chk($sformatf("legal_busy_k%0d", k), int'(busy), (k <= 7) ? 1 : 0);
        chk($sformatf("legal_clk_mode_k%0d", k), int'(clk_mode), (k >= 3) ? 5 : 2);
      end
      adv();
    end

    // Rejected request, divisor 1
    t = cyc;
    req1 = 1'b1;
    mode1 = 31'd1;
    sb_q.push_back(exp_t'{1, 1, 5, t + 1});
    for (int k = 0; k <= 2; k++) begin
      at_neg();
      chk($sformatf("rej_div_rst_n_k%0d", k), int'(div_rst_n), 1);
      chk($sformatf("rej_clk_mode_k%0d", k), int'(clk_mode), 5);
      chk($sformatf("rej_busy_k%0d", k), int'(busy), (k == 1) ? 1 : 0);
      adv();
    end

    // Reset in the middle of SETTLE aborts without ack
    t = cyc;
    req0 = 1'b1;
    mode0 = 31'd9;
    advn(4);
    at_neg();
    chk("settle_clk_mode", int'(clk_mode), 9);
    chk("settle_busy", int'(busy), 1);
    rst_n = 1'b0;
    req0 = 1'b0;
    adv();
    at_neg();
    chk("abort_clk_mode", int'(clk_mode), 2);
    chk("abort_div_rst_n", int'(div_rst_n), 0);
    chk("abort_busy", int'(busy), 0);
    adv();
    rst_n = 1'b1;
    adv();
    at_neg();
    chk("abort_rel_div_rst_n", int'(div_rst_n), 1);
    advn(10);

    // Simultaneous requests after reset: requester 0 first
    t = cyc;
    req0 = 1'b1;
    mode0 = 31'd4;
    req1 = 1'b1;
    mode1 = 31'd7;
    sb_q.push_back(exp_t'{0, 0, 4, t + 7});
    sb_q.push_back(exp_t'{1, 0, 7, t + 15});
    advn(17);

    // Both held continuously: grants alternate 0,1,0,1; divisor 2 is the legal edge
    keep0 = 1'b1;
    keep1 = 1'b1;
    t = cyc;
    req0 = 1'b1;
    mode0 = 31'd2;
    req1 = 1'b1;
    mode1 = 31'd6;
    sb_q.push_back(exp_t'{0, 0, 2, t + 7});
    sb_q.push_back(exp_t'{1, 0, 6, t + 15});
    sb_q.push_back(exp_t'{0, 0, 2, t + 23});
    sb_q.push_back(exp_t'{1, 0, 6, t + 31});
    advn(32);
    keep0 = 1'b0;
    keep1 = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    advn(3);

    // Request raised while busy waits and is served with full latency
    t = cyc;
    req0 = 1'b1;
    mode0 = 31'd8;
    sb_q.push_back(exp_t'{0, 0, 8, t + 7});
    adv();
    req1 = 1'b1;
    mode1 = 31'h4000_0000;
    sb_q.push_back(exp_t'{1, 0, 32'h4000_0000, t + 15});
    advn(17);

    advn(3);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
